// File: rtl/alu_issue_ctrl.sv
// RV32I issue/capture around a combinational ALU: decode to selector and operands
// in stage 1, turn the ALU result into writeback or redirect outcomes in stage 2.
module alu_issue_ctrl #(
   parameter int XLEN = 32,
   parameter int OP_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   output logic [OP_W-1:0] operationSelector,
   output logic [XLEN-1:0] operandA,
   output logic [XLEN-1:0] operandB,
   input  logic [XLEN-1:0] outputResult,
   input  logic            zeroFlag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      out_rd,
   output logic            out_wb_en,
   output logic [XLEN-1:0] out_wb_data,
   output logic            out_redirect,
   output logic [XLEN-1:0] out_target,
   output logic            out_illegal
);

   localparam logic [OP_W-1:0] OP_AND   = OP_W'(5'b00000);
   localparam logic [OP_W-1:0] OP_OR    = OP_W'(5'b00001);
   localparam logic [OP_W-1:0] OP_ADD   = OP_W'(5'b00010);
   localparam logic [OP_W-1:0] OP_SUB   = OP_W'(5'b00011);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5'b00100);
   localparam logic [OP_W-1:0] OP_BLT   = OP_W'(5'b00101);
   localparam logic [OP_W-1:0] OP_BNE   = OP_W'(5'b00110);
   localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(5'b00111);
   localparam logic [OP_W-1:0] OP_BGE   = OP_W'(5'b01000);
   localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(5'b01001);
   localparam logic [OP_W-1:0] OP_XOR   = OP_W'(5'b01010);
   localparam logic [OP_W-1:0] OP_SLT   = OP_W'(5'b01011);
   localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(5'b01100);
   localparam logic [OP_W-1:0] OP_SLL   = OP_W'(5'b01110);
   localparam logic [OP_W-1:0] OP_SRL   = OP_W'(5'b01111);
   localparam logic [OP_W-1:0] OP_SRA   = OP_W'(5'b10000);
   localparam logic [OP_W-1:0] OP_PASSB = OP_W'(5'b10001);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   // funct3 to ALU op; alt selects SUB/SRA where that encoding exists
   function automatic logic [OP_W-1:0] aluOp(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  aluOp = alt ? OP_SUB : OP_ADD;
         3'b001:  aluOp = OP_SLL;
         3'b010:  aluOp = OP_SLT;
         3'b011:  aluOp = OP_SLTU;
         3'b100:  aluOp = OP_XOR;
         3'b101:  aluOp = alt ? OP_SRA : OP_SRL;
         3'b110:  aluOp = OP_OR;
         default: aluOp = OP_AND;
      endcase
   endfunction

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [4:0]      rdField;
   logic [XLEN-1:0] immI, immS, immB, immU, immJ;

   assign opcode  = in_instr[6:0];
   assign funct3  = in_instr[14:12];
   assign funct7  = in_instr[31:25];
   assign rdField = in_instr[11:7];
   assign immI = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
   assign immS = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign immB = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
   assign immU = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'b0};
   assign immJ = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                  in_instr[20], in_instr[30:21], 1'b0};

   logic [OP_W-1:0] decSel;
   logic [XLEN-1:0] decA, decB;
   logic            decWb, decIllegal, decBranch, decJal, decJalr;

   always_comb begin
      decSel     = OP_ADD;
      decA       = in_rs1;
      decB       = immI;
      decWb      = 1'b0;
      decIllegal = 1'b0;
      decBranch  = 1'b0;
      decJal     = 1'b0;
      decJalr    = 1'b0;
      case (opcode)
         OPC_OP: begin
            decB   = in_rs2;
            decWb  = 1'b1;
            decSel = aluOp(funct3, funct7[5]);
            if (funct7 == 7'b0100000)
               decIllegal = !(funct3 == 3'b000 || funct3 == 3'b101);
            else if (funct7 != 7'b0000000)
               decIllegal = 1'b1;
         end
         OPC_IMM: begin
            decWb  = 1'b1;
            decSel = aluOp(funct3, (funct3 == 3'b101) && funct7[5]);
            if (funct3 == 3'b001)
               decIllegal = (funct7 != 7'b0000000);
            else if (funct3 == 3'b101)
               decIllegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
         end
         OPC_LOAD: begin
            decWb      = 1'b1;
            decIllegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
         end
         OPC_STORE: begin
            decB       = immS;
            decIllegal = funct3[2] || (funct3 == 3'b011);
         end
         OPC_JALR: begin
            decWb      = 1'b1;
            decJalr    = 1'b1;
            decIllegal = (funct3 != 3'b000);
         end
         OPC_JAL: begin
            decA   = in_pc;
            decB   = immJ;
            decWb  = 1'b1;
            decJal = 1'b1;
         end
         OPC_AUIPC: begin
            decA  = in_pc;
            decB  = immU;
            decWb = 1'b1;
         end
         OPC_LUI: begin
            decSel = OP_PASSB;
            decB   = immU;
            decWb  = 1'b1;
         end
         OPC_BRANCH: begin
            decB      = in_rs2;
            decBranch = 1'b1;
            case (funct3)
               3'b000:  decSel = OP_BEQ;
               3'b001:  decSel = OP_BNE;
               3'b100:  decSel = OP_BLT;
               3'b101:  decSel = OP_BGE;
               3'b110:  decSel = OP_BLTU;
               3'b111:  decSel = OP_BGEU;
               default: decIllegal = 1'b1;
            endcase
         end
         default: decIllegal = 1'b1;
      endcase
      // illegal words become inert ADDs that still flow to stage 2
      if (decIllegal) begin
         decSel    = OP_ADD;
         decWb     = 1'b0;
         decBranch = 1'b0;
         decJal    = 1'b0;
         decJalr   = 1'b0;
      end
      if (rdField == 5'd0)
         decWb = 1'b0;
   end

   logic            s1ValidReg, s1WbReg, s1IllegalReg, s1BranchReg, s1JalReg, s1JalrReg;
   logic [4:0]      s1RdReg;
   logic [XLEN-1:0] s1TargetReg, s1LinkReg;
   logic            s1Load, s2Load;

   // stage 1 only advances together with stage 2, keeping the ALU inputs stable under stall
   assign in_ready = !s1ValidReg || !out_valid || out_ready;
   assign s1Load   = in_valid && in_ready;
   assign s2Load   = s1ValidReg && (!out_valid || out_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1ValidReg        <= 1'b0;
         s1WbReg           <= 1'b0;
         s1IllegalReg      <= 1'b0;
         s1BranchReg       <= 1'b0;
         s1JalReg          <= 1'b0;
         s1JalrReg         <= 1'b0;
         s1RdReg           <= '0;
         s1TargetReg       <= '0;
         s1LinkReg         <= '0;
         operationSelector <= OP_ADD;
         operandA          <= '0;
         operandB          <= '0;
      end else if (s1Load) begin
         s1ValidReg        <= 1'b1;
         s1WbReg           <= decWb;
         s1IllegalReg      <= decIllegal;
         s1BranchReg       <= decBranch;
         s1JalReg          <= decJal;
         s1JalrReg         <= decJalr;
         s1RdReg           <= rdField;
         s1TargetReg       <= in_pc + immB;
         s1LinkReg         <= in_pc + XLEN'(4);
         operationSelector <= decSel;
         operandA          <= decA;
         operandB          <= decB;
      end else if (s2Load) begin
         s1ValidReg <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_rd       <= '0;
         out_wb_en    <= 1'b0;
         out_wb_data  <= '0;
         out_redirect <= 1'b0;
         out_target   <= '0;
         out_illegal  <= 1'b0;
      end else if (s2Load) begin
         out_valid   <= 1'b1;
         out_rd      <= s1RdReg;
         out_wb_en   <= s1WbReg;
         out_illegal <= s1IllegalReg;
         if (s1BranchReg) begin
            out_redirect <= zeroFlag;
            out_target   <= s1TargetReg;
            out_wb_data  <= outputResult;
         end else if (s1JalReg || s1JalrReg) begin
            out_redirect <= 1'b1;
            out_target   <= s1JalrReg ? {outputResult[XLEN-1:1], 1'b0} : outputResult;
            out_wb_data  <= s1LinkReg;
         end else begin
            out_redirect <= 1'b0;
            out_target   <= '0;
            out_wb_data  <= outputResult;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, vector table with hand-derived results,
// scoreboard queue filled on acceptance and drained by an output monitor.
module tb_alu_issue_ctrl;

   logic        clk, rst_n;
   logic        in_valid, in_ready;
   logic [31:0] in_instr, in_pc, in_rs1, in_rs2;
   logic [4:0]  operationSelector;
   logic [31:0] operandA, operandB, outputResult;
   logic        zeroFlag;
   logic        out_valid, out_ready;
   logic [4:0]  out_rd;
   logic        out_wb_en, out_redirect, out_illegal;
   logic [31:0] out_wb_data, out_target;

   alu_issue_ctrl #(.XLEN(32), .OP_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .operationSelector(operationSelector), .operandA(operandA), .operandB(operandB),
      .outputResult(outputResult), .zeroFlag(zeroFlag),
      .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
      .out_wb_en(out_wb_en), .out_wb_data(out_wb_data), .out_redirect(out_redirect),
      .out_target(out_target), .out_illegal(out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference ALU; for branch selectors zeroFlag means "condition true"
   always_comb begin
      outputResult = 32'h0;
      zeroFlag     = 1'b0;
      case (operationSelector)
         5'b00000: outputResult = operandA & operandB;
         5'b00001: outputResult = operandA | operandB;
         5'b00010: outputResult = operandA + operandB;
         5'b00011: outputResult = operandA - operandB;
         5'b01010: outputResult = operandA ^ operandB;
         5'b01011: outputResult = {31'b0, $signed(operandA) < $signed(operandB)};
         5'b01100: outputResult = {31'b0, operandA < operandB};
         5'b01110: outputResult = operandA << operandB[4:0];
         5'b01111: outputResult = operandA >> operandB[4:0];
         5'b10000: outputResult = $signed(operandA) >>> operandB[4:0];
         5'b10001: outputResult = operandB;
         default:  outputResult = operandA - operandB;
      endcase
      case (operationSelector)
         5'b00100: zeroFlag = (operandA == operandB);
         5'b00110: zeroFlag = (operandA != operandB);
         5'b00101: zeroFlag = $signed(operandA) < $signed(operandB);
         5'b01000: zeroFlag = $signed(operandA) >= $signed(operandB);
         5'b00111: zeroFlag = operandA < operandB;
         5'b01001: zeroFlag = operandA >= operandB;
         default:  zeroFlag = (outputResult == 32'h0);
      endcase
   end

   typedef struct {
      logic [31:0] instr, pc, rs1, rs2;
      logic [4:0]  sel;
      logic [31:0] opB;
      logic [4:0]  rd;
      logic        wb;
      logic [31:0] data;
      logic        redir, tgtCare;
      logic [31:0] tgt;
      logic        ill;
   } vec_t;

   localparam int NVEC = 18;
   vec_t vecs[NVEC];
   vec_t expq[$];
   int   errors = 0, checks = 0, outCount = 0;
   logic randReady = 1'b0;
   logic held = 1'b0;
   logic [70:0] snap;

   function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] encS(input logic [11:0] imm, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] encB(input logic [12:0] imm, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] encJ(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic issue(input int i, output int waits);
      logic r;
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = vecs[i].pc;
      in_rs1   = vecs[i].rs1;
      in_rs2   = vecs[i].rs2;
      waits    = 0;
      forever begin
         @(negedge clk);
         r = in_ready;
         @(posedge clk);
         #1;
         if (r) break;
         waits++;
         if (waits > 50) break;
      end
      in_valid = 1'b0;
      if (waits > 50) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: vector %0d not accepted in 50 cycles", i);
      end else begin
         expq.push_back(vecs[i]);
         chk($sformatf("sel[%0d]", i), {27'b0, operationSelector}, {27'b0, vecs[i].sel});
         chk($sformatf("opB[%0d]", i), operandB, vecs[i].opB);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (expq.size() > 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_left", expq.size(), 0);
   endtask

   // output monitor: scoreboard pop on transfer, stability check while stalled
   initial begin
      vec_t e;
      logic [70:0] cur;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            held = 1'b0;
         end else if (out_valid) begin
            cur = {out_rd, out_wb_en, out_wb_data, out_redirect, out_target, out_illegal};
            if (held) begin
               checks++;
               if (cur !== snap) begin
                  errors++;
                  $display("FAIL hold_stable: got %h, expected %h", cur, snap);
               end
            end
            if (out_ready) begin
               held = 1'b0;
               if (expq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_out: got rd=%0d data=0x%08h, expected none", out_rd, out_wb_data);
               end else begin
                  e = expq.pop_front();
                  outCount++;
                  $display("out #%0d: instr=0x%08h rd=%0d wb=%0b data=0x%08h redir=%0b tgt=0x%08h ill=%0b",
                           outCount, e.instr, out_rd, out_wb_en, out_wb_data, out_redirect, out_target, out_illegal);
                  chk("wb_en", {31'b0, out_wb_en}, {31'b0, e.wb});
                  chk("redirect", {31'b0, out_redirect}, {31'b0, e.redir});
                  chk("illegal", {31'b0, out_illegal}, {31'b0, e.ill});
                  if (e.wb) begin
                     chk("rd", {27'b0, out_rd}, {27'b0, e.rd});
                     chk("wb_data", out_wb_data, e.data);
                  end
                  if (e.tgtCare) chk("target", out_target, e.tgt);
               end
            end else begin
               snap = cur;
               held = 1'b1;
            end
         end else begin
            held = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (randReady) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, stalls;
      //          instr                                        pc            rs1           rs2           sel       opB           rd     wb    data          redir tc    tgt           ill
      vecs[0]  = '{encR(7'h00, 5'd2, 5'd1, 3'b000, 5'd3),      32'h0,        32'hF,        32'hF,        5'b00010, 32'hF,        5'd3,  1'b1, 32'h1E,       1'b0, 1'b0, 32'h0,        1'b0};
      vecs[1]  = '{encB(13'd16, 5'd2, 5'd1, 3'b100),           32'h100,      32'hF,        32'hF000000F, 5'b00101, 32'hF000000F, 5'd0,  1'b0, 32'h0,        1'b0, 1'b1, 32'h110,      1'b0};
      vecs[2]  = '{encB(13'd16, 5'd2, 5'd1, 3'b110),           32'h100,      32'hF,        32'hF000000F, 5'b00111, 32'hF000000F, 5'd0,  1'b0, 32'h0,        1'b1, 1'b1, 32'h110,      1'b0};
      vecs[3]  = '{encI(12'd15, 5'd1, 3'b001, 5'd5, 7'h13),    32'h0,        32'hF,        32'h0,        5'b01110, 32'hF,        5'd5,  1'b1, 32'h78000,    1'b0, 1'b0, 32'h0,        1'b0};
      vecs[4]  = '{encJ(21'd8, 5'd1),                          32'hFFFFFFFC, 32'h0,        32'h0,        5'b00010, 32'h8,        5'd1,  1'b1, 32'h0,        1'b1, 1'b1, 32'h4,        1'b0};
      vecs[5]  = '{encR(7'h20, 5'd7, 5'd6, 3'b000, 5'd4),      32'h0,        32'hA,        32'h3,        5'b00011, 32'h3,        5'd4,  1'b1, 32'h7,        1'b0, 1'b0, 32'h0,        1'b0};
      vecs[6]  = '{encI(12'h404, 5'd1, 3'b101, 5'd8, 7'h13),   32'h0,        32'hF0000000, 32'h0,        5'b10000, 32'h404,      5'd8,  1'b1, 32'hFF000000, 1'b0, 1'b0, 32'h0,        1'b0};
      vecs[7]  = '{{20'hABCDE, 5'd9, 7'h37},                   32'h0,        32'h0,        32'h0,        5'b10001, 32'hABCDE000, 5'd9,  1'b1, 32'hABCDE000, 1'b0, 1'b0, 32'h0,        1'b0};
      vecs[8]  = '{{20'h00001, 5'd10, 7'h17},                  32'h200,      32'h0,        32'h0,        5'b00010, 32'h1000,     5'd10, 1'b1, 32'h1200,     1'b0, 1'b0, 32'h0,        1'b0};
      vecs[9]  = '{encI(12'd5, 5'd2, 3'b000, 5'd1, 7'h67),     32'h300,      32'h1000,     32'h0,        5'b00010, 32'h5,        5'd1,  1'b1, 32'h304,      1'b1, 1'b1, 32'h1004,     1'b0};
      vecs[10] = '{encI(12'd1, 5'd1, 3'b000, 5'd0, 7'h13),     32'h0,        32'h5,        32'h0,        5'b00010, 32'h1,        5'd0,  1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
      vecs[11] = '{encS(12'hFFC, 5'd2, 5'd1, 3'b010),          32'h0,        32'h100,      32'hDEADBEEF, 5'b00010, 32'hFFFFFFFC, 5'd0,  1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
      vecs[12] = '{32'h0000007F,                               32'h0,        32'h1,        32'h2,        5'b00010, 32'h0,        5'd0,  1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1};
      vecs[13] = '{encR(7'h01, 5'd2, 5'd1, 3'b000, 5'd13),     32'h0,        32'h4,        32'h3,        5'b00010, 32'h3,        5'd0,  1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1};
      vecs[14] = '{encR(7'h00, 5'd2, 5'd1, 3'b010, 5'd11),     32'h0,        32'hFFFFFFFF, 32'h1,        5'b01011, 32'h1,        5'd11, 1'b1, 32'h1,        1'b0, 1'b0, 32'h0,        1'b0};
      vecs[15] = '{encB(13'h1FF8, 5'd2, 5'd1, 3'b001),         32'h400,      32'h1,        32'h2,        5'b00110, 32'h2,        5'd0,  1'b0, 32'h0,        1'b1, 1'b1, 32'h3F8,      1'b0};
      vecs[16] = '{encI(12'h40F, 5'd1, 3'b001, 5'd5, 7'h13),   32'h0,        32'hF,        32'h0,        5'b00010, 32'h40F,      5'd0,  1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1};
      vecs[17] = '{encI(12'hFFF, 5'd1, 3'b100, 5'd12, 7'h13),  32'h0,        32'h0F0F0F0F, 32'h0,        5'b01010, 32'hFFFFFFFF, 5'd12, 1'b1, 32'hF0F0F0F0, 1'b0, 1'b0, 32'h0,        1'b0};

      rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
      in_rs1 = 32'h0; in_rs2 = 32'h0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_sel", {27'b0, operationSelector}, 32'h2);
      chk("rst_opA", operandA, 32'h0);
      chk("rst_opB", operandB, 32'h0);
      chk("rst_outs", {out_valid, out_wb_en, out_redirect, out_illegal, out_rd}, 32'h0);
      chk("rst_data", out_wb_data | out_target, 32'h0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
      @(posedge clk);
      #1;

      // single-cycle latency: accepted at edge N, visible after edge N+1
      issue(0, w);
      chk("lat_before", {31'b0, out_valid}, 32'h0);
      @(posedge clk);
      #1;
      chk("lat_after", {31'b0, out_valid}, 32'h1);
      drain();

      // full-rate stream with the consumer always ready
      stalls = 0;
      for (int i = 0; i < NVEC; i++) begin
         issue(i, w);
         stalls += w;
      end
      chk("stream_stalls", stalls, 0);
      drain();

      // same table under random consumer backpressure
      randReady = 1'b1;
      for (int i = NVEC - 1; i >= 0; i--) issue(i, w);
      randReady = 1'b0;
      out_ready = 1'b1;
      drain();

      // consumer stalls for three cycles after the first instruction
      issue(0, w);
      out_ready = 1'b0;
      fork
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join_none
      issue(1, w);
      chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
      issue(2, w);
      chk("bp_waited", {31'b0, w > 0}, 32'h1);
      issue(3, w);
      drain();

      // reset with both stages full discards everything
      out_ready = 1'b0;
      issue(5, w);
      issue(6, w);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", {31'b0, out_valid}, 32'h0);
      expq.delete();
      held = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_rel_valid", {31'b0, out_valid}, 32'h0);
      issue(12, w);
      chk("rst_lat_before", {31'b0, out_valid}, 32'h0);
      @(posedge clk);
      #1;
      chk("rst_lat_after", {31'b0, out_valid}, 32'h1);
      chk("rst_illegal", {31'b0, out_illegal}, 32'h1);
      chk("rst_wb_en", {31'b0, out_wb_en}, 32'h0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
